// File: rtl/loop_uhat_acc_pkg.sv
// Shared widths and FSM state type for the sparse-row product accumulator.
// Imported by the top module and by its output register.
package loop_uhat_acc_pkg;

    localparam int DIN_W_DEF  = 75;
    localparam int ACC_W_DEF  = 80;
    localparam int DOUT_W_DEF = 64;
    localparam int SHIFT_DEF  = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_HOLD
    } acc_state_e;

endpackage

// File: rtl/loop_uhat_acc_outreg.sv
// One-deep valid/ready output register for finished row results.
// Loads only when ready_o is high; otherwise holds contents stable.
module loop_uhat_acc_outreg
    import loop_uhat_acc_pkg::*;
#(
    parameter int DOUT_WIDTH = DOUT_W_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [DOUT_WIDTH-1:0] data_i,
    input  logic [CNT_WIDTH-1:0]  count_i,
    input  logic [CNT_WIDTH-1:0]  row_i,
    input  logic                  ovf_i,
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DOUT_WIDTH-1:0] data_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [CNT_WIDTH-1:0]  row_o,
    output logic                  ovf_o
);

    logic                  valid_q, valid_d;
    logic [DOUT_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  row_q, row_d;
    logic                  ovf_q, ovf_d;

    assign ready_o = !valid_q || ready_i;

    // Next contents: new result replaces old, else drop when consumed.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        row_d   = row_q;
        ovf_d   = ovf_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            count_d = count_i;
            row_d   = row_i;
            ovf_d   = ovf_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Result register with async clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;
    assign row_o   = row_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/loop_uhat_sparse_prod_acc.sv
// Sparse-row accumulator: sums product beats per row, rounds and scales.
// Define LOOP_UHAT_ACC_SAT_EN to clip oversized results instead of truncating.
module loop_uhat_sparse_prod_acc
    import loop_uhat_acc_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_W_DEF,
    parameter int ACC_WIDTH  = ACC_W_DEF,
    parameter int DOUT_WIDTH = DOUT_W_DEF,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic [CNT_WIDTH-1:0]  out_row,
    output logic                  out_ovf
);

    localparam logic [ACC_WIDTH:0] RND =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);

    acc_state_e            state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  row_q, row_d;
    logic                  ovf_q, ovf_d;

    logic                  fire;
    logic                  load;
    logic [ACC_WIDTH:0]    sum;
    logic                  row_ovf;
    logic [ACC_WIDTH:0]    rnd;
    logic [ACC_WIDTH:0]    scaled;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [DOUT_WIDTH-1:0] res;
    logic                  res_ovf;

    assign fire    = in_valid && in_ready;
    assign sum     = {1'b0, acc_q}
                   + {{(ACC_WIDTH + 1 - DIN_WIDTH){1'b0}}, in_data};
    assign row_ovf = ovf_q || sum[ACC_WIDTH];
    assign rnd     = {1'b0, sum[ACC_WIDTH-1:0]} + RND;
    assign scaled  = rnd >> SHIFT;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef LOOP_UHAT_ACC_SAT_EN
    logic big;
    assign big     = |scaled[ACC_WIDTH:DOUT_WIDTH];
    assign res_ovf = big || row_ovf;
    assign res     = res_ovf ? '1 : scaled[DOUT_WIDTH-1:0];
`else
    logic unused_hi;
    assign unused_hi = |scaled[ACC_WIDTH:DOUT_WIDTH];
    assign res       = scaled[DOUT_WIDTH-1:0];
    assign res_ovf   = row_ovf;
`endif

    // Datapath next state: accumulate, or close the row on a last beat.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        row_d = row_q;
        ovf_d = ovf_q;
        load  = 1'b0;
        if (fire) begin
            if (in_last) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
                row_d = row_q + 1'b1;
                load  = 1'b1;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
                cnt_d = cnt_inc;
                ovf_d = row_ovf;
            end
        end
    end

    // FSM next state: row progress, or HOLD while the result is stalled.
    always_comb begin
        state_d = state_q;
        if (fire) begin
            state_d = in_last ? ST_IDLE : ST_ACC;
        end else if (out_valid && !out_ready) begin
            state_d = ST_HOLD;
        end else begin
            unique case (state_q)
                ST_HOLD: state_d = (cnt_q != '0) ? ST_ACC : ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Accumulator, counters and FSM state with async clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
        end
    end

    loop_uhat_acc_outreg #(
        .DOUT_WIDTH (DOUT_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_outreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (load),
        .data_i  (res),
        .count_i (cnt_inc),
        .row_i   (row_q),
        .ovf_i   (res_ovf),
        .ready_o (in_ready),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (out_data),
        .count_o (out_count),
        .row_o   (out_row),
        .ovf_o   (out_ovf)
    );

endmodule

// File: tb/tb_loop_uhat_sparse_prod_acc.sv
// Scoreboard bench for loop_uhat_sparse_prod_acc with a row-sum reference model.
// Honours LOOP_UHAT_ACC_SAT_EN for the expected clipping behaviour.
module tb_loop_uhat_sparse_prod_acc;

    localparam int DW = 75;
    localparam int AW = 80;
    localparam int OW = 64;
    localparam int SH = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic [CW-1:0] out_row;
    logic          out_ovf;

    loop_uhat_sparse_prod_acc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_row   (out_row),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] d;
        logic [CW-1:0] c;
        logic [CW-1:0] r;
        logic          o;
    } exp_t;

    exp_t        q[$];
    int          nchk = 0;
    int          nerr = 0;
    logic [95:0] m_acc = '0;
    bit          m_ovf = 1'b0;
    int          m_cnt = 0;
    int          m_row = 0;
    bit          rnd_rdy = 1'b0;
    int          prev_row = -1;
    bit          saw_wrap = 1'b0;

    function automatic void model_beat(input logic [DW-1:0] d, input logic last);
        exp_t        e;
        logic [95:0] r;
        m_acc = m_acc + 96'(d);
        if (m_acc >= (96'd1 << AW)) begin
            m_ovf = 1'b1;
            m_acc = m_acc - (96'd1 << AW);
        end
        if (m_cnt < 65535) m_cnt++;
        if (last) begin
            r   = (m_acc + (96'd1 << (SH - 1))) >> SH;
            e.c = m_cnt[CW-1:0];
            e.r = m_row[CW-1:0];
            e.o = m_ovf;
`ifdef LOOP_UHAT_ACC_SAT_EN
            if (m_ovf || r >= (96'd1 << OW)) begin
                e.d = '1;
                e.o = 1'b1;
            end else begin
                e.d = r[OW-1:0];
            end
`else
            e.d = r[OW-1:0];
`endif
            q.push_back(e);
            m_row = (m_row + 1) % 65536;
            m_acc = '0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one beat from posedge+1 and returns once it is accepted.
    task automatic drive_beat(input logic [DW-1:0] d, input logic last,
                              output int waits);
        bit done;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waits    = 0;
        done     = 1'b0;
        while (!done) begin
            if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            waits++;
            if (in_ready) begin
                model_beat(d, last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done && waits > 200) begin
                nchk++;
                nerr++;
                $display("FAIL accept_timeout: got no accept expected accept");
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Monitor: every transferred result must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_result: got row %0d expected none",
                         out_row);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 128'({out_data, out_count, out_row, out_ovf}),
                      128'(e));
            end
            if (prev_row == 65535 && out_row == 0) saw_wrap = 1'b1;
            prev_row = int'(out_row);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int            w;
        int            total;
        int            n;
        logic [DW-1:0] big;
        logic [OW-1:0] snap_d;
        logic [CW-1:0] snap_r;
        logic [CW-1:0] snap_c;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_cnt_row_ovf", 128'({out_count, out_row, out_ovf}), 128'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;

        drive_beat(DW'(256), 1'b0, w);
        drive_beat(DW'(512), 1'b0, w);
        drive_beat(DW'(256), 1'b1, w);
        check("sum3_valid", 128'(out_valid), 128'(1));
        check("sum3_data", 128'(out_data), 128'(4));
        check("sum3_count", 128'(out_count), 128'(3));
        check("sum3_row", 128'(out_row), 128'(0));

        drive_beat(DW'(384), 1'b1, w);
        check("round_up", 128'(out_data), 128'(2));
        drive_beat(DW'(383), 1'b1, w);
        check("round_down", 128'(out_data), 128'(1));

        big = DW'(1) << 74;
        drive_beat(big, 1'b1, w);
`ifdef LOOP_UHAT_ACC_SAT_EN
        check("clip_data", 128'(out_data), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        check("clip_ovf", 128'(out_ovf), 128'(1));
`else
        check("clip_data", 128'(out_data), 128'(0));
        check("clip_ovf", 128'(out_ovf), 128'(0));
`endif
        for (int i = 0; i < 64; i++) drive_beat(big, (i == 63), w);
        check("accovf_ovf", 128'(out_ovf), 128'(1));

        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_beat(DW'(1024), 1'b1, w);
        snap_d = out_data;
        snap_r = out_row;
        snap_c = out_count;
        in_valid = 1'b1;
        in_data  = DW'(512);
        in_last  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_frozen", 128'({out_valid, out_data, out_row, out_count}),
                  128'({1'b1, snap_d, snap_r, snap_c}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_beat(DW'(512), 1'b1, w);
        check("bp_accept_latency", 128'(w), 128'(1));
        check("bp_new_data", 128'(out_data), 128'(2));

        rnd_rdy = 1'b1;
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++)
                drive_beat(DW'({$urandom, $urandom}) >> 24, (b == n - 1), w);
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rand_drained", 128'(q.size()), 128'(0));

        total = 0;
        for (int i = 0; i < 70000; i++) begin
            drive_beat(DW'($urandom), 1'b1, w);
            total += w;
        end
        check("stream_no_bubble", 128'(total), 128'(70000));
        repeat (3) @(posedge clk);
        #1;
        check("stream_row_wrap", 128'(saw_wrap), 128'(1));
        check("stream_drained", 128'(q.size()), 128'(0));

        drive_beat(DW'(100), 1'b0, w);
        drive_beat(DW'(200), 1'b0, w);
        reset_n = 1'b0;
        m_acc = '0;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_row = 0;
        q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_valid", 128'(out_valid), 128'(0));
        end
        @(posedge clk);
        #1;
        drive_beat(DW'(256), 1'b1, w);
        check("mid_rst_row", 128'({out_data, out_count, out_row}),
              128'({64'd1, 16'd1, 16'd0}));
        repeat (3) @(posedge clk);
        #1;
        check("final_drained", 128'(q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/loop_uhat_sparse_prod_acc.md
LOOP_UHAT_SPARSE_PROD_ACC -- requirements
Module: loop_uhat_sparse_prod_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 75: width of the unsigned product from the upstream 71x4 multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 80: width of the row accumulator; must be at least DIN_WIDTH.
REQ-003 SHALL have parameter DOUT_WIDTH, default 64: width of the result word.
REQ-004 SHALL have parameter SHIFT, default 8: fixed-point right shift applied at row end.
REQ-005 SHALL have parameter CNT_WIDTH, default 16: width of the term counter and the row counter.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: product beat valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-010 SHALL have port in_data, input, DIN_WIDTH bits: unsigned product.
REQ-011 SHALL have port in_last, input, 1 bit: beat is the final term of its sparse row.
REQ-012 SHALL have port out_valid, output, 1 bit: row result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port out_data, output, DOUT_WIDTH bits: rounded, scaled row sum.
REQ-015 SHALL have port out_count, output, CNT_WIDTH bits: number of terms in the row.
REQ-016 SHALL have port out_row, output, CNT_WIDTH bits: row index.
REQ-017 SHALL have port out_ovf, output, 1 bit: accumulator overflowed within the row, or the result was clipped.

Function
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both high.
REQ-019 in_ready SHALL equal (!out_valid || out_ready).
REQ-020 The FSM SHALL have three states:
- IDLE: accumulator zero, no terms held.
- ACC: at least one term held.
- HOLD: out_valid high and out_ready low.
REQ-021 On an accepted non-last beat, the FSM SHALL go from IDLE or ACC to ACC, with acc <= acc + in_data and the term count incremented.
REQ-022 On an accepted last beat, the block SHALL compute sum = acc + in_data and result = (sum + 2^(SHIFT-1)) >> SHIFT, then register the following, with out_valid rising on the next cycle:
- out_data <= result;
- out_count <= term count + 1;
- out_row <= row counter;
- accumulator and term count cleared, FSM to IDLE.
REQ-023 Latency from the accepted last beat to out_valid SHALL be exactly 1 cycle; throughput SHALL be 1 beat per cycle with no bubbles between rows.
REQ-024 If out_valid is high and out_ready is low, the FSM SHALL enter or stay in HOLD, with all outputs stable and in_ready low.
REQ-025 If out_ready is high in the same cycle a new last beat is accepted, the new result SHALL replace the old one with out_valid staying high.
REQ-026 When out_valid && out_ready and no last beat is accepted, out_valid SHALL fall on the next cycle.
REQ-027 The row counter SHALL increment on each last beat and wrap from 2^CNT_WIDTH-1 to 0.
REQ-028 The term counter SHALL saturate at 2^CNT_WIDTH-1.
REQ-029 A carry out of ACC_WIDTH SHALL set a per-row overflow bit, which is reported in out_ovf and cleared at row end.

Reset
REQ-030 While reset_n is low, the block SHALL hold these values:
- FSM in IDLE;
- acc, term count and row counter at 0;
- out_valid, out_data, out_count, out_row and out_ovf at 0;
- in_ready at 1 after release.
REQ-031 Reset asserted mid-row SHALL discard the partial row, with no result emitted.

Configuration
REQ-032 With LOOP_UHAT_ACC_SAT_EN defined:
- an oversized result SHALL clip to 2^DOUT_WIDTH-1 and set out_ovf;
- an accumulator overflow SHALL force the clipped result.
REQ-033 Without LOOP_UHAT_ACC_SAT_EN:
- the result SHALL be truncated to its low DOUT_WIDTH bits;
- out_ovf SHALL reflect only the accumulator carry.

Structure
REQ-034 A shared package loop_uhat_acc_pkg SHALL hold:
- the default width constants;
- the FSM state enum (IDLE/ACC/HOLD).
REQ-035 The output register and handshake SHALL be one sub-module, loop_uhat_acc_outreg (a 1-deep valid/ready register); the datapath and FSM SHALL stay in the top module.

Verification
REQ-036 The bench SHALL cover three-term summation: beats 256, 512, 256(last) with out_ready=1 -> out_data=4, out_count=3, out_row=0, one cycle after the last beat.
REQ-037 The bench SHALL cover rounding: single beat 384(last) -> out_data=2; single beat 383(last) -> out_data=1.
REQ-038 The bench SHALL cover clipping: single beat 2^74(last) -> with the macro, out_data=0xFFFFFFFFFFFFFFFF and out_ovf=1; without the macro, out_data=0.
REQ-039 The bench SHALL cover backpressure: out_ready=0 after a last beat -> in_ready low and outputs frozen for 10 cycles; on out_ready=1, the held beat is accepted the same cycle, with no loss or duplication.
REQ-040 The bench SHALL cover back-to-back rows: 70000 single-beat rows -> out_row wraps 65535 to 0, and no bubble cycles occur with out_ready tied high.
REQ-041 The bench SHALL cover reset mid-row: two beats accepted, then reset_n pulsed low -> no out_valid; the next row 256(last) gives out_data=1, out_count=1, out_row=0.
